// File: rtl/neuron_mac_sequencer.sv
// Weighted-sum sequencer for one neuron: feeds operand pairs one term at a time
// to a shared multiplier lane, accumulates the products and hands the sum off.
module neuron_mac_sequencer #(
    parameter int N_INPUTS = 32,
    parameter int WIDTH    = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [N_INPUTS-1:0][WIDTH-1:0]     in,
    input  logic [N_INPUTS:0][WIDTH-1:0]       constant,
    output logic                               busy,
    output logic                               mul_req,
    output logic [WIDTH-1:0]                   mul_a,
    output logic [WIDTH-1:0]                   mul_b,
    input  logic                               mul_grant,
    input  logic [WIDTH-1:0]                   mul_p,
    output logic [5:0]                         term,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   sum
);

    localparam int IDX_W = $clog2(N_INPUTS);
    localparam logic [5:0] LAST_TERM = 6'(N_INPUTS);
    // Bias operand A is the constant -2; paired with -bias_weight it yields +2*bias.
    localparam logic [WIDTH-1:0] BIAS_A = ~WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [WIDTH-1:0]                acc_q, acc_d;
    logic [5:0]                      term_q, term_d;
    logic [N_INPUTS-1:0][WIDTH-1:0]  in_q, in_d;
    logic [N_INPUTS:0][WIDTH-1:0]    w_q, w_d;

    // NOTE: every register, including the captured vectors, is cleared by reset so an
    // aborted neuron leaves nothing behind; nothing relies on that content being stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            term_q  <= '0;
            in_q    <= '0;
            w_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments here so all flops update from the same
            // pre-edge values; the combinational block below uses blocking ones.
            state_q <= state_d;
            acc_q   <= acc_d;
            term_q  <= term_d;
            in_q    <= in_d;
            w_q     <= w_d;
        end
    end

    // NOTE: every output and *_d signal gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        term_d    = term_q;
        in_d      = in_q;
        w_d       = w_q;
        busy      = 1'b0;
        mul_req   = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        out_valid = 1'b0;
        sum       = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    in_d    = in;
                    w_d     = constant;
                    acc_d   = '0;
                    term_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                busy    = 1'b1;
                mul_req = 1'b1;
                if (term_q == LAST_TERM) begin
                    mul_a = BIAS_A;
                    mul_b = -w_q[N_INPUTS];
                end else begin
                    mul_a = in_q[term_q[IDX_W-1:0]];
                    mul_b = w_q[term_q];
                end
                // A withheld grant simply replays the same term next cycle.
                if (mul_grant) begin
                    acc_d = acc_q + mul_p;
                    if (term_q == LAST_TERM) begin
                        state_d = DONE;
                    end else begin
                        term_d = term_q + 6'd1;
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                sum       = acc_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign term = term_q;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Self-checking bench for neuron_mac_sequencer: directed vector table, hand-written
// backpressure/reset sequences, and randomized neurons against a dot-product model.
module tb_neuron_mac_sequencer;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [31:0][31:0]     in;
    logic [32:0][31:0]     constant;
    logic                  busy;
    logic                  mul_req;
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;
    logic                  mul_grant;
    logic [31:0]           mul_p;
    logic [5:0]            term;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           sum;

    logic [31:0][31:0]     in_v;
    logic [32:0][31:0]     c_v;
    logic [31:0]           seen_bias_a;
    logic [31:0]           seen_bias_b;

    int checks = 0;
    int errors = 0;

    neuron_mac_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in        (in),
        .constant  (constant),
        .busy      (busy),
        .mul_req   (mul_req),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_grant (mul_grant),
        .mul_p     (mul_p),
        .term      (term),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    // Shared lane: combinational product, truncated to 32 bits.
    assign mul_p = mul_a * mul_b;

    typedef struct {
        logic [31:0] in_fill;
        logic [31:0] in0;
        logic [31:0] c_fill;
        logic [31:0] c0;
        logic [31:0] bias;
        logic [31:0] exp_sum;
        int          gmode;
        int          exp_lat;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] ref_sum();
        logic [31:0] s = 32'd0;
        for (int k = 0; k < 32; k++) s += in_v[k] * c_v[k];
        s += 32'hFFFF_FFFE * (32'd0 - c_v[32]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one neuron from IDLE. gmode: 0 grant always, 1 grant on even cycles, 2 random.
    // hold: cycles of out_ready low in DONE, with start pulsed throughout.
    task automatic run_neuron(input int gmode, input logic [31:0] exp_sum, input int exp_lat,
                              input int hold, input string name);
        int          cyc;
        int          k;
        int          bad;
        logic        g;
        logic [31:0] ea;
        logic [31:0] eb;
        in       = in_v;
        constant = c_v;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check({name, " busy_after_start"}, 32'(busy), 32'd1);
        in       = ~in_v;
        constant = ~c_v;
        k   = 0;
        bad = 0;
        cyc = 1;
        while (!out_valid && cyc < 300) begin
            case (gmode)
                0:       g = 1'b1;
                1:       g = (cyc % 2 == 0);
                default: g = ($urandom_range(0, 3) != 0);
            endcase
            mul_grant = g;
            #1;
            ea = (k < 32) ? in_v[k] : 32'hFFFF_FFFE;
            eb = (k < 32) ? c_v[k] : (32'd0 - c_v[32]);
            if (k == 32) begin
                seen_bias_a = mul_a;
                seen_bias_b = mul_b;
            end
            if (mul_req !== 1'b1 || term !== 6'(k) || mul_a !== ea || mul_b !== eb) bad++;
            if (g) k++;
            tick();
            cyc++;
        end
        check({name, " issue_trace_errs"}, 32'(bad), 32'd0);
        check({name, " grants_before_valid"}, 32'(k), 32'd33);
        if (exp_lat >= 0) check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check({name, " sum"}, sum, exp_sum);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            start     = 1'b1;
            mul_grant = 1'($urandom_range(0, 1));
            out_ready = 1'b0;
            tick();
            if (out_valid !== 1'b1 || sum !== exp_sum || mul_req !== 1'b0 || busy !== 1'b1) bad++;
        end
        if (hold > 0) check({name, " hold_stable_errs"}, 32'(bad), 32'd0);
        start     = 1'b0;
        mul_grant = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " idle_valid"}, 32'(out_valid), 32'd0);
        check({name, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic load_vec(input vec_t v);
        for (int k = 0; k < 32; k++) begin
            in_v[k] = v.in_fill;
            c_v[k]  = v.c_fill;
        end
        in_v[0] = v.in0;
        c_v[0]  = v.c0;
        c_v[32] = v.bias;
    endtask

    task automatic load_random();
        for (int k = 0; k < 32; k++) begin
            in_v[k] = $urandom;
            c_v[k]  = $urandom;
        end
        c_v[32] = $urandom;
    endtask

    vec_t table_v[4];

    initial begin
        int guard;
        table_v[0] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd32, 0, 34, "ones"};
        table_v[1] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd6, 0, 34, "bias_only"};
        table_v[2] = '{32'd0, 32'h7FFF_FFFF, 32'd0, 32'd2, 32'd0, 32'hFFFF_FFFE, 0, 34, "wrap"};
        table_v[3] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd32, 1, 67, "grant_toggle"};

        reset       = 1'b1;
        start       = 1'b0;
        mul_grant   = 1'b1;
        out_ready   = 1'b0;
        in          = '0;
        constant    = '0;
        seen_bias_a = '0;
        seen_bias_b = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst mul_req", 32'(mul_req), 32'd0);
        check("rst mul_a", mul_a, 32'd0);
        check("rst mul_b", mul_b, 32'd0);
        check("rst term", 32'(term), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst sum", sum, 32'd0);

        for (int i = 0; i < 4; i++) begin
            load_vec(table_v[i]);
            run_neuron(table_v[i].gmode, table_v[i].exp_sum, table_v[i].exp_lat, 0, table_v[i].name);
            if (i == 1) begin
                check("bias mul_a", seen_bias_a, 32'hFFFF_FFFE);
                check("bias mul_b", seen_bias_b, 32'hFFFF_FFFD);
            end
        end

        // Ten cycles of backpressure in DONE with start pulsed throughout.
        load_vec(table_v[0]);
        run_neuron(0, 32'd32, 34, 10, "backpressure");

        // Reset while term 15 is on the lane, then a fresh neuron.
        load_random();
        in        = in_v;
        constant  = c_v;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        mul_grant = 1'b1;
        guard     = 0;
        while (term !== 6'd15 && guard < 40) begin
            tick();
            guard++;
        end
        check("midreset reached_term15", 32'(term), 32'd15);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        mul_grant = 1'b0;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset term", 32'(term), 32'd0);
        check("midreset sum", sum, 32'd0);
        check("midreset mul_req", 32'(mul_req), 32'd0);
        check("midreset out_valid", 32'(out_valid), 32'd0);
        load_random();
        run_neuron(0, ref_sum(), 34, 0, "after_reset");

        for (int r = 0; r < 6; r++) begin
            load_random();
            run_neuron(2, ref_sum(), -1, $urandom_range(0, 3), $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
